// File: rtl/uart_rx_pkg.sv
// Shared UART receiver constants and helpers: prescale legality, frame length
// and the majority-vote sample window around mid-bit.
package uart_rx_pkg;

  localparam int DEFAULT_PRESCALE = 8;
  localparam int MIN_PRESCALE     = 8;

  // Sample edges relative to M = P/2 (three-point majority vote).
  localparam int SAMP_OFS_LO  = -2;
  localparam int SAMP_OFS_MID = -1;
  localparam int SAMP_OFS_HI  = 0;

  function automatic logic presc_legal(input int unsigned p, input int unsigned max_p);
    return (p[0] == 1'b0) && (p >= MIN_PRESCALE) && (p <= max_p);
  endfunction

  // start + data + optional parity + stop + optional second stop
  function automatic int unsigned frame_len(input int unsigned dw, input logic par,
                                            input logic stop2);
    return dw + 32'd2 + 32'(par) + 32'(stop2);
  endfunction

endpackage

// File: rtl/rx_cfg_latch.sv
// Per-frame configuration latch: validates Prescale, substitutes the default
// on an illegal value and flags it until a legal value is captured.
module rx_cfg_latch
  import uart_rx_pkg::*;
#(
  parameter int MAX_PRESCALE = 32,
  parameter int PRESC_W      = $clog2(MAX_PRESCALE) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               capture,
  input  logic               PAR_EN,
  input  logic               STOP2,
  input  logic [PRESC_W-1:0] Prescale,
  output logic [PRESC_W-1:0] p_q,
  output logic               par_q,
  output logic               stop2_q,
  output logic               cfg_err
);

  logic legal;
  assign legal = presc_legal(32'(Prescale), MAX_PRESCALE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q     <= PRESC_W'(DEFAULT_PRESCALE);
      par_q   <= 1'b0;
      stop2_q <= 1'b0;
      cfg_err <= 1'b0;
    end else if (capture) begin
      p_q     <= legal ? Prescale : PRESC_W'(DEFAULT_PRESCALE);
      par_q   <= PAR_EN;
      stop2_q <= STOP2;
      cfg_err <= ~legal;
    end
  end

endmodule

// File: rtl/rx_frame_counter.sv
// Oversampling edge/bit counter for the UART receiver; decodes mid-bit sample
// strobes and end-of-bit / end-of-frame pulses, wrapping for back-to-back frames.
module rx_frame_counter
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int MAX_PRESCALE = 32,
  parameter int PRESC_W      = $clog2(MAX_PRESCALE) + 1,
  parameter int EDGE_W       = $clog2(MAX_PRESCALE),
  parameter int BIT_W        = $clog2(DATA_WIDTH + 5)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               PAR_EN,
  input  logic               STOP2,
  input  logic [PRESC_W-1:0] Prescale,
  output logic [EDGE_W-1:0]  edge_cnt,
  output logic [BIT_W-1:0]   bit_cnt,
  output logic               samp_en,
  output logic               samp_last,
  output logic               bit_last,
  output logic               frame_done,
  output logic               cfg_err
);

  logic [PRESC_W-1:0] p_q, p_m1, m, edge_ext;
  logic               par_q, stop2_q, capture;
  logic [BIT_W-1:0]   flen_m1;

  // Idle cycles and the frame-wrap edge are the only capture points.
  assign capture = ~enable | frame_done;

  rx_cfg_latch #(
    .MAX_PRESCALE (MAX_PRESCALE),
    .PRESC_W      (PRESC_W)
  ) u_cfg (
    .clk      (clk),
    .rst      (rst),
    .capture  (capture),
    .PAR_EN   (PAR_EN),
    .STOP2    (STOP2),
    .Prescale (Prescale),
    .p_q      (p_q),
    .par_q    (par_q),
    .stop2_q  (stop2_q),
    .cfg_err  (cfg_err)
  );

  assign p_m1     = p_q - PRESC_W'(1);
  assign m        = p_q >> 1;
  assign edge_ext = PRESC_W'(edge_cnt);
  assign flen_m1  = BIT_W'(frame_len(DATA_WIDTH, par_q, stop2_q) - 32'd1);

  assign bit_last   = enable & (edge_ext == p_m1);
  assign frame_done = bit_last & (bit_cnt == flen_m1);
  assign samp_last  = enable & (edge_ext == m + PRESC_W'(SAMP_OFS_HI));
  assign samp_en    = enable & ((edge_ext == m + PRESC_W'(SAMP_OFS_LO))  |
                                (edge_ext == m + PRESC_W'(SAMP_OFS_MID)) |
                                (edge_ext == m + PRESC_W'(SAMP_OFS_HI)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (!enable) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (bit_last) begin
      edge_cnt <= '0;
      bit_cnt  <= (bit_cnt == flen_m1) ? '0 : bit_cnt + BIT_W'(1);
    end else begin
      edge_cnt <= edge_cnt + EDGE_W'(1);
    end
  end

endmodule

// File: tb/tb_rx_frame_counter.sv
// Directed bench for rx_frame_counter: per-cycle expected counts and strobes
// come from a small reference model keyed on (P, FRAME_LEN, cycle-in-run).
module tb_rx_frame_counter;

  localparam int DATA_WIDTH   = 8;
  localparam int MAX_PRESCALE = 32;
  localparam int PRESC_W      = $clog2(MAX_PRESCALE) + 1;
  localparam int EDGE_W       = $clog2(MAX_PRESCALE);
  localparam int BIT_W        = $clog2(DATA_WIDTH + 5);

  logic               clk = 1'b0;
  logic               rst;
  logic               enable;
  logic               PAR_EN;
  logic               STOP2;
  logic [PRESC_W-1:0] Prescale;
  logic [EDGE_W-1:0]  edge_cnt;
  logic [BIT_W-1:0]   bit_cnt;
  logic               samp_en, samp_last, bit_last, frame_done, cfg_err;

  int n_tests = 0;
  int n_fail  = 0;

  rx_frame_counter #(
    .DATA_WIDTH   (DATA_WIDTH),
    .MAX_PRESCALE (MAX_PRESCALE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .PAR_EN     (PAR_EN),
    .STOP2      (STOP2),
    .Prescale   (Prescale),
    .edge_cnt   (edge_cnt),
    .bit_cnt    (bit_cnt),
    .samp_en    (samp_en),
    .samp_last  (samp_last),
    .bit_last   (bit_last),
    .frame_done (frame_done),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change 2 time units after the active edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_cycle(input int p, input int flen, input int c, input string tag);
    int e, b, m;
    e = c % p;
    b = (c / p) % flen;
    m = p / 2;
    #1;
    chk({tag, ".edge"},  int'(edge_cnt),   e);
    chk({tag, ".bit"},   int'(bit_cnt),    b);
    chk({tag, ".samp"},  int'(samp_en),    int'(e >= m - 2 && e <= m));
    chk({tag, ".slast"}, int'(samp_last),  int'(e == m));
    chk({tag, ".blast"}, int'(bit_last),   int'(e == p - 1));
    chk({tag, ".fdone"}, int'(frame_done), int'(e == p - 1 && b == flen - 1));
  endtask

  task automatic run(input int p, input int flen, input int c0, input int n, input string tag);
    for (int i = c0; i < c0 + n; i++) begin
      chk_cycle(p, flen, i, tag);
      step();
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".edge"},  int'(edge_cnt),   0);
    chk({tag, ".bit"},   int'(bit_cnt),    0);
    chk({tag, ".samp"},  int'(samp_en),    0);
    chk({tag, ".slast"}, int'(samp_last),  0);
    chk({tag, ".blast"}, int'(bit_last),   0);
    chk({tag, ".fdone"}, int'(frame_done), 0);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; PAR_EN = 1'b0; STOP2 = 1'b0; Prescale = 8;
    #3;
    chk_quiet("rst");
    chk("rst.err", int'(cfg_err), 0);
    step(); step();
    rst = 1'b0;
    step();

    // P=8, 8N1: FRAME_LEN=10, frame_done at cycle 79, wrap at 80
    enable = 1'b1;
    run(8, 10, 0, 81, "p8");

    // P=16, parity, 2 stop: FRAME_LEN=12, three back-to-back frames
    enable = 1'b0; Prescale = 16; PAR_EN = 1'b1; STOP2 = 1'b1;
    step();
    enable = 1'b1;
    run(16, 12, 0, 3 * 192 + 1, "p16");

    // Prescale 16->32 mid-frame takes effect only after the wrap
    enable = 1'b0; Prescale = 16; PAR_EN = 1'b0; STOP2 = 1'b0;
    step();
    enable = 1'b1;
    run(16, 10, 0, 50, "chg16");
    Prescale = 32;
    run(16, 10, 50, 110, "chg16b");
    run(32, 10, 0, 321, "chg32");

    // Legality at idle: 12 ok, 7 -> P=8 with error, 34 illegal, 10 ok
    enable = 1'b0; Prescale = 12;
    step();
    #1 chk("p12.err", int'(cfg_err), 0);
    enable = 1'b1;
    run(12, 10, 0, 13, "p12");
    enable = 1'b0; Prescale = 7;
    step();
    #1 chk("p7.err", int'(cfg_err), 1);
    enable = 1'b1;
    run(8, 10, 0, 81, "p7");
    #1 chk("p7.err_hold", int'(cfg_err), 1);
    enable = 1'b0; Prescale = 34;
    step();
    #1 chk("p34.err", int'(cfg_err), 1);
    Prescale = 10;
    step();
    #1 chk("p10.err", int'(cfg_err), 0);
    enable = 1'b1;
    run(10, 10, 0, 12, "p10");

    // enable dropped at bit 4: strobes gate off, counts clear next edge
    enable = 1'b0; Prescale = 8;
    step();
    enable = 1'b1;
    run(8, 10, 0, 35, "drop");
    enable = 1'b0;
    #1;
    chk("drop.bit_hold", int'(bit_cnt), 4);
    chk("drop.samp",     int'(samp_en), 0);
    chk("drop.fdone",    int'(frame_done), 0);
    step();
    #1 chk_quiet("drop.idle");
    enable = 1'b1;
    run(8, 10, 0, 10, "reen");

    // Async reset mid-count also restores the default P=8
    enable = 1'b0; Prescale = 16;
    step();
    enable = 1'b1;
    run(16, 10, 0, 53, "prerst");
    #1;
    chk("prerst.edge", int'(edge_cnt), 5);
    chk("prerst.bit",  int'(bit_cnt),  3);
    rst = 1'b1;
    #1;
    chk_quiet("arst");
    chk("arst.err", int'(cfg_err), 0);
    step();
    rst = 1'b0;
    run(8, 10, 0, 17, "postrst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
